// File: rtl/mem_pkg.sv
// Shared types for the mem_responder slice: data width, FSM states and the latched request.
package mem_pkg;

    localparam int XLEN  = 32;
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_e;

    typedef struct packed {
        logic                  we;
        logic [XLEN-1:0]       adr;
        logic [XLEN-1:0]       wdata;
        logic [XLEN/8-1:0]     be;
    } mem_req_t;

endpackage

// File: rtl/mem_be_write.sv
// Byte-lane merge: each lane with its enable set takes wdata, the rest keep the old word.
module mem_be_write
    import mem_pkg::*;
#(
    parameter int xlen = XLEN
) (
    input  logic [xlen-1:0]   old_word_i,
    input  logic [xlen-1:0]   wdata_i,
    input  logic [xlen/8-1:0] be_i,
    output logic [xlen-1:0]   new_word_o
);

    // NOTE: the output gets a full default before the loop, so no lane can infer a latch.
    always_comb begin
        new_word_o = old_word_i;
        for (int i = 0; i < xlen / 8; i++) begin
            if (be_i[i]) begin
                new_word_o[8*i +: 8] = wdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory slave with valid/ready request/response and programmable wait states.
// Optional misaligned-access error response: define MEM_MISALIGN_ERR_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int xlen    = XLEN,
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [xlen-1:0]   req_adr,
    input  logic [xlen-1:0]   req_wdata,
    input  logic [xlen/8-1:0] req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [xlen-1:0]   resp_data,
    output logic              resp_err
);

    localparam int              AW     = $clog2(DEPTH);
    localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(LATENCY > 0 ? LATENCY - 1 : 0);

    mem_state_e       state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    mem_req_t         req_q, req_d;
    logic             resp_valid_q, resp_valid_d;
    logic [xlen-1:0]  resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;

    mem_req_t         cur_req;
    logic             enter_resp;
    logic             misalign;
    logic             mem_we;
    logic [AW-1:0]    idx;
    logic [xlen-1:0]  old_word;
    logic [xlen-1:0]  new_word;
    logic [xlen-1:0]  data [DEPTH];

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

    // The request that reaches RESP this edge: the live bus in IDLE (LATENCY 0), the latch otherwise.
    always_comb begin
        cur_req = req_q;
        if (state_q == IDLE) begin
            cur_req = '{we: req_we, adr: req_adr, wdata: req_wdata, be: req_be};
        end
    end

    assign idx = cur_req.adr[AW+1:2];

`ifdef MEM_MISALIGN_ERR_EN
    assign misalign = (cur_req.adr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    logic unused_adr;
    assign unused_adr = ^{cur_req.adr[xlen-1:AW+2], cur_req.adr[1:0]};

    assign old_word = data[idx];
    assign mem_we   = enter_resp && cur_req.we && !misalign;

    mem_be_write #(.xlen(xlen)) u_be_write (
        .old_word_i (old_word),
        .wdata_i    (cur_req.wdata),
        .be_i       (cur_req.be),
        .new_word_o (new_word)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        enter_resp   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = cur_req;
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            resp_valid_d = 1'b1;
            resp_err_d   = misalign;
            resp_data_d  = (cur_req.we || misalign) ? '0 : old_word;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // NOTE: the storage array has no reset; it is preloaded externally and must map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            data[idx] <= new_word;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: unit 0 is LATENCY=2/DEPTH=4096, unit 1 is LATENCY=0/DEPTH=16.
module tb_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_adr    [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_be     [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_data  [2];
    logic        resp_err   [2];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] got_d;
    logic        got_e;

    mem_responder #(.xlen(32), .DEPTH(4096), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_adr(req_adr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_data(resp_data[0]), .resp_err(resp_err[0])
    );

    mem_responder #(.xlen(32), .DEPTH(16), .LATENCY(0)) dut_l0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_adr(req_adr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_data(resp_data[1]), .resp_err(resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request and hold it through exactly one accepting edge.
    task automatic start(input int u, input logic we, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [3:0] be);
        req_valid[u] = 1'b1;
        req_we[u]    = we;
        req_adr[u]   = adr;
        req_wdata[u] = wd;
        req_be[u]    = be;
        check("req_ready_idle", {31'b0, req_ready[u]}, 32'd1);
        @(posedge clk);
        #1;
        req_valid[u] = 1'b0;
    endtask

    // Count cycles from the accept edge until resp_valid is seen; bounded at 20.
    task automatic wait_resp(input int u, input int lat);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            n = i;
            if (resp_valid[u]) break;
            check("req_ready_busy", {31'b0, req_ready[u]}, 32'd0);
        end
        if (!resp_valid[u]) n = 99;
        check("resp_latency", n, lat + 1);
        got_d = resp_data[u];
        got_e = resp_err[u];
    endtask

    // Hold backpressure for `hold` cycles, then complete the handshake.
    task automatic finish(input int u, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, resp_valid[u]}, 32'd1);
            check("bp_data", resp_data[u], got_d);
            check("bp_ready", {31'b0, req_ready[u]}, 32'd0);
        end
        resp_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[u] = 1'b0;
        @(negedge clk);
        check("post_hs_valid", {31'b0, resp_valid[u]}, 32'd0);
        check("post_hs_data", resp_data[u], 32'd0);
        check("post_hs_ready", {31'b0, req_ready[u]}, 32'd1);
    endtask

    task automatic txn(input int u, input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       input logic [3:0] be, input int lat, input logic [31:0] exp_d,
                       input logic exp_e, input string tag);
        start(u, we, adr, wd, be);
        wait_resp(u, lat);
        check(tag, got_d, exp_d);
        check({tag, "_err"}, {31'b0, got_e}, {31'b0, exp_e});
        finish(u, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u]  = 1'b0;
            req_we[u]     = 1'b0;
            req_adr[u]    = '0;
            req_wdata[u]  = '0;
            req_be[u]     = '0;
            resp_ready[u] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready[0]}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid[0]}, 32'd0);
        check("rst_resp_data", resp_data[0], 32'd0);
        check("rst_resp_err", {31'b0, resp_err[0]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload through the bus, then read back with LATENCY=2.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, 32'h0, 1'b0, "wr_w4");
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDEADBEEF, 1'b0, "rd_w4");

        // Byte-enable merge and be=0 no-op write.
        txn(0, 1'b1, 32'h4, 32'h11223344, 4'hF, 2, 32'h0, 1'b0, "wr_w1");
        txn(0, 1'b1, 32'h4, 32'hAABBCCDD, 4'b0101, 2, 32'h0, 1'b0, "wr_be5");
        txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 2, 32'h11BB33DD, 1'b0, "rd_be5");
        txn(0, 1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, 2, 32'h0, 1'b0, "wr_be0");
        txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 2, 32'h11BB33DD, 1'b0, "rd_be0");

        // Backpressure: five stalled cycles before the handshake.
        start(0, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_resp(0, 2);
        check("bp_first", got_d, 32'hDEADBEEF);
        finish(0, 5);

        // resp_ready raised early must not disturb latency.
        resp_ready[0] = 1'b1;
        start(0, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_resp(0, 2);
        check("early_ready", got_d, 32'hDEADBEEF);
        finish(0, 0);

        // LATENCY=0, DEPTH=16: byte address 0x40 wraps to word 0.
        txn(1, 1'b1, 32'h40, 32'hCAFE0001, 4'hF, 0, 32'h0, 1'b0, "l0_wr_wrap");
        txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'hCAFE0001, 1'b0, "l0_rd_wrap");

        // Reset while a write is in WAIT: outputs clear without a clock edge, write is dropped.
        start(0, 1'b1, 32'h10, 32'h0, 4'hF);
        @(negedge clk);
        check("wait_busy", {31'b0, req_ready[0]}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_wait_valid", {31'b0, resp_valid[0]}, 32'd0);
        check("rst_wait_ready", {31'b0, req_ready[0]}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_spurious", {31'b0, resp_valid[0]}, 32'd0);
        end
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 2, 32'hDEADBEEF, 1'b0, "rd_after_drop");

        // Reset while a read sits in RESP: data clears immediately.
        start(0, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_resp(0, 2);
        check("resp_held", got_d, 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1;
        check("rst_resp_v", {31'b0, resp_valid[0]}, 32'd0);
        check("rst_resp_d", resp_data[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while a write sits in RESP: the write has already committed.
        start(0, 1'b1, 32'h20, 32'h12345678, 4'hF);
        wait_resp(0, 2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_wresp_v", {31'b0, resp_valid[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 2, 32'h12345678, 1'b0, "rd_committed");

        // Misaligned accesses.
`ifdef MEM_MISALIGN_ERR_EN
        txn(0, 1'b0, 32'h6, 32'h0, 4'h0, 2, 32'h0, 1'b1, "mis_rd");
        txn(0, 1'b1, 32'h5, 32'h0, 4'hF, 2, 32'h0, 1'b1, "mis_wr");
        txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 2, 32'h11BB33DD, 1'b0, "mis_unchanged");
`else
        txn(0, 1'b0, 32'h6, 32'h0, 4'h0, 2, 32'h11BB33DD, 1'b0, "mis_rd");
        txn(0, 1'b1, 32'h5, 32'h0, 4'hF, 2, 32'h0, 1'b0, "mis_wr");
        txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 2, 32'h0, 1'b0, "mis_aligned_down");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
